// File: rtl/ss_addsub_win.sv
// Signed stochastic adder/subtractor with per-stream sliding windows.
// Difference counter turns the signed input stream sum into a sign/magnitude bitstream.
module ss_addsub_win #(
  parameter int N   = 6,
  parameter int WIN = 16,
  parameter int CW  = 8,
  localparam int SW = $clog2(N*WIN+1)
) (
  input  logic          CLK,
  input  logic          INIT_n,
  input  logic          EN,
  input  logic          CLR,
  input  logic [N-1:0]  IN,
  input  logic [N-1:0]  SIGN,
  output logic          OUT,
  output logic          SIGN_out,
  output logic [SW-1:0] SUM_POS,
  output logic [SW-1:0] SUM_NEG,
  output logic          WFULL,
  output logic          OVF
);

  localparam int CPW = $clog2(N+1);
  localparam int DW  = CW + $clog2(N) + 1;
  localparam int FW  = $clog2(WIN+1);
  localparam logic signed [DW-1:0] DMAX = DW'((2**(CW-1))-1);
  localparam logic signed [DW-1:0] DMIN = -DMAX;

  logic [N-1:0][WIN-1:0] pwin_q, pwin_d;
  logic [N-1:0][WIN-1:0] nwin_q, nwin_d;
  logic [N-1:0]          pos, neg;
  logic [CPW-1:0]        cp, cn, lp, ln;
  logic [SW-1:0]         spos_q, spos_d;
  logic [SW-1:0]         sneg_q, sneg_d;
  logic signed [CW-1:0]  d_q, d_d;
  logic signed [DW-1:0]  d_ext, emit;
  logic                  out_q, out_d;
  logic                  sgn_q, sgn_d;
  logic                  ovf_q, ovf_d;
  logic [FW-1:0]         fill_q, fill_d;

  always_comb begin
    pos = IN & ~SIGN;
    neg = IN & SIGN;
    cp  = '0;
    cn  = '0;
    lp  = '0;
    ln  = '0;
    for (int n = 0; n < N; n++) begin
      cp = cp + CPW'(pos[n]);
      cn = cn + CPW'(neg[n]);
      lp = lp + CPW'(pwin_q[n][WIN-1]);
      ln = ln + CPW'(nwin_q[n][WIN-1]);
    end
  end

  // emit is +1/-1/0 from the sign of the current count
  always_comb begin
    if (d_q[CW-1])
      emit = '1;
    else if (d_q != '0)
      emit = DW'(1);
    else
      emit = '0;
    d_ext = {{(DW-CW){d_q[CW-1]}}, d_q}
          + {{(DW-CPW){1'b0}}, cp}
          - {{(DW-CPW){1'b0}}, cn}
          - emit;
  end

  always_comb begin
    pwin_d = pwin_q;
    nwin_d = nwin_q;
    spos_d = spos_q;
    sneg_d = sneg_q;
    d_d    = d_q;
    out_d  = out_q;
    sgn_d  = sgn_q;
    ovf_d  = ovf_q;
    fill_d = fill_q;
    if (CLR) begin
      pwin_d = '0;
      nwin_d = '0;
      spos_d = '0;
      sneg_d = '0;
      d_d    = '0;
      out_d  = 1'b0;
      sgn_d  = 1'b0;
      ovf_d  = 1'b0;
      fill_d = '0;
    end else if (EN) begin
      for (int n = 0; n < N; n++) begin
        pwin_d[n] = {pwin_q[n][WIN-2:0], pos[n]};
        nwin_d[n] = {nwin_q[n][WIN-2:0], neg[n]};
      end
      spos_d = spos_q + SW'(cp) - SW'(lp);
      sneg_d = sneg_q + SW'(cn) - SW'(ln);
      out_d  = (d_q != '0);
      sgn_d  = d_q[CW-1];
      if (d_ext > DMAX) begin
        d_d   = DMAX[CW-1:0];
        ovf_d = 1'b1;
      end else if (d_ext < DMIN) begin
        d_d   = DMIN[CW-1:0];
        ovf_d = 1'b1;
      end else begin
        d_d   = d_ext[CW-1:0];
      end
      fill_d = (fill_q == FW'(WIN)) ? fill_q : fill_q + FW'(1);
    end
  end

  always_ff @(posedge CLK or negedge INIT_n) begin
    if (!INIT_n) begin
      pwin_q <= '0;
      nwin_q <= '0;
      spos_q <= '0;
      sneg_q <= '0;
      d_q    <= '0;
      out_q  <= 1'b0;
      sgn_q  <= 1'b0;
      ovf_q  <= 1'b0;
      fill_q <= '0;
    end else begin
      pwin_q <= pwin_d;
      nwin_q <= nwin_d;
      spos_q <= spos_d;
      sneg_q <= sneg_d;
      d_q    <= d_d;
      out_q  <= out_d;
      sgn_q  <= sgn_d;
      ovf_q  <= ovf_d;
      fill_q <= fill_d;
    end
  end

  assign OUT      = out_q;
  assign SIGN_out = sgn_q;
  assign SUM_POS  = spos_q;
  assign SUM_NEG  = sneg_q;
  assign WFULL    = (fill_q == FW'(WIN));
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_ss_addsub_win.sv
// Bench for ss_addsub_win: two instances (CW=8 and CW=4) on shared stimulus,
// checked against a window-history / integer-counter reference model.
module tb_ss_addsub_win;

  localparam int N   = 6;
  localparam int WIN = 16;
  localparam int SW  = $clog2(N*WIN+1);
  localparam int VW  = 8 + 4*SW;

  logic          clk = 1'b0;
  logic          init_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  in_v = '0;
  logic [N-1:0]  sign_v = '0;
  logic          out, sign_out, wfull, ovf;
  logic [SW-1:0] sum_pos, sum_neg;
  logic          out4, sign_out4, wfull4, ovf4;
  logic [SW-1:0] sum_pos4, sum_neg4;

  int checks = 0;
  int errors = 0;

  int          m_d8, m_d4, m_fill;
  bit          m_o8, m_s8, m_ovf8;
  bit          m_o4, m_s4, m_ovf4;
  logic [N-1:0] hp[$];
  logic [N-1:0] hn[$];

  always #5 clk = ~clk;

  ss_addsub_win #(.N(N), .WIN(WIN), .CW(8)) dut (
    .CLK(clk), .INIT_n(init_n), .EN(en), .CLR(clr),
    .IN(in_v), .SIGN(sign_v),
    .OUT(out), .SIGN_out(sign_out),
    .SUM_POS(sum_pos), .SUM_NEG(sum_neg),
    .WFULL(wfull), .OVF(ovf)
  );

  ss_addsub_win #(.N(N), .WIN(WIN), .CW(4)) dut4 (
    .CLK(clk), .INIT_n(init_n), .EN(en), .CLR(clr),
    .IN(in_v), .SIGN(sign_v),
    .OUT(out4), .SIGN_out(sign_out4),
    .SUM_POS(sum_pos4), .SUM_NEG(sum_neg4),
    .WFULL(wfull4), .OVF(ovf4)
  );

  task automatic model_reset();
    m_d8 = 0; m_d4 = 0; m_fill = 0;
    m_o8 = 0; m_s8 = 0; m_ovf8 = 0;
    m_o4 = 0; m_s4 = 0; m_ovf4 = 0;
    hp.delete();
    hn.delete();
  endtask

  task automatic dstep(inout int d, inout bit ov, output bit o,
                       output bit s, input int lim, input int net);
    int e;
    int nd;
    o  = (d != 0);
    s  = (d < 0);
    e  = (d > 0) ? 1 : ((d < 0) ? -1 : 0);
    nd = d + net - e;
    if (nd > lim) begin nd = lim; ov = 1; end
    if (nd < -lim) begin nd = -lim; ov = 1; end
    d = nd;
  endtask

  task automatic model_step(input bit e, input bit c,
                            input logic [N-1:0] i, input logic [N-1:0] s);
    int net;
    if (c) begin
      model_reset();
    end else if (e) begin
      net = $countones(i & ~s) - $countones(i & s);
      dstep(m_d8, m_ovf8, m_o8, m_s8, 127, net);
      dstep(m_d4, m_ovf4, m_o4, m_s4, 7, net);
      hp.push_back(i & ~s);
      hn.push_back(i & s);
      if (hp.size() > WIN) begin
        void'(hp.pop_front());
        void'(hn.pop_front());
      end
      if (m_fill < WIN) m_fill++;
    end
  endtask

  function automatic int psum(input bit negw);
    int t = 0;
    for (int k = 0; k < hp.size(); k++)
      t += negw ? $countones(hn[k]) : $countones(hp[k]);
    return t;
  endfunction

  function automatic logic [VW-1:0] expv();
    logic f;
    f = (m_fill == WIN);
    return {m_o8, m_s8, SW'(psum(0)), SW'(psum(1)), f, m_ovf8,
            m_o4, m_s4, m_ovf4, SW'(psum(0)), SW'(psum(1)), f};
  endfunction

  function automatic logic [VW-1:0] obsv();
    return {out, sign_out, sum_pos, sum_neg, wfull, ovf,
            out4, sign_out4, ovf4, sum_pos4, sum_neg4, wfull4};
  endfunction

  task automatic step(input bit e, input bit c,
                      input logic [N-1:0] i, input logic [N-1:0] s);
    en = e; clr = c; in_v = i; sign_v = s;
    @(posedge clk);
    model_step(e, c, i, s);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if (obsv() !== '0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", obsv());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obsv() !== expv()) begin
      errors++;
      $display("FAIL reset_hold got %h want %h", obsv(), expv());
    end
    init_n = 1'b1;
  endtask

  task automatic test_all_pos();
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 6'b000011, 6'b000000);
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL allpos_model k=%0d got %h want %h", k, obsv(), expv());
      end
      if (k >= 2) begin
        checks++;
        if ({out, sign_out} !== 2'b10) begin
          errors++;
          $display("FAIL allpos_out k=%0d got %b want 10", k, {out, sign_out});
        end
      end
      if (k == 15) begin
        checks++;
        if (wfull !== 1'b0) begin
          errors++;
          $display("FAIL allpos_wfull15 got %b want 0", wfull);
        end
      end
    end
    checks++;
    if ({sum_pos, sum_neg, wfull} !== {SW'(32), SW'(0), 1'b1}) begin
      errors++;
      $display("FAIL allpos_sums got %0d/%0d/%b want 32/0/1",
               sum_pos, sum_neg, wfull);
    end
  endtask

  task automatic test_cancel();
    step(1, 1, 6'b000011, 6'b000000);
    checks++;
    if (obsv() !== '0) begin
      errors++;
      $display("FAIL cancel_clr got %h want 0", obsv());
    end
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 6'b000011, 6'b000010);
      checks++;
      if (out !== 1'b0 || obsv() !== expv()) begin
        errors++;
        $display("FAIL cancel k=%0d got %h want %h", k, obsv(), expv());
      end
    end
    checks++;
    if ({sum_pos, sum_neg} !== {SW'(16), SW'(16)}) begin
      errors++;
      $display("FAIL cancel_sums got %0d/%0d want 16/16", sum_pos, sum_neg);
    end
  endtask

  task automatic test_saturate();
    step(0, 1, 6'b000000, 6'b000000);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 6'b111111, 6'b000000);
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL sat_model k=%0d got %h want %h", k, obsv(), expv());
      end
      if (k >= 2) begin
        checks++;
        if (ovf4 !== 1'b1 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL sat_ovf k=%0d got %b%b want 10", k, ovf4, ovf);
        end
      end
    end
    for (int j = 0; j < 8; j++) begin
      step(1, 0, 6'b000000, 6'b000000);
      checks++;
      if (out4 !== (j < 7) || ovf4 !== 1'b1) begin
        errors++;
        $display("FAIL sat_drain j=%0d got out4=%b ovf4=%b want %b/1",
                 j, out4, ovf4, (j < 7));
      end
    end
  endtask

  task automatic test_negative();
    int integ = 0;
    step(1, 1, 6'b000000, 6'b000000);
    for (int k = 1; k <= 30; k++) begin
      step(1, 0, (k <= 5) ? 6'b000001 : 6'b000000, 6'b000001);
      integ += out ? (sign_out ? -1 : 1) : 0;
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL neg_model k=%0d got %h want %h", k, obsv(), expv());
      end
      if (k == 20 || k == 21) begin
        checks++;
        if (sum_neg !== SW'(21 - k)) begin
          errors++;
          $display("FAIL neg_window k=%0d got %0d want %0d", k, sum_neg, 21 - k);
        end
      end
    end
    checks++;
    if (integ !== -5) begin
      errors++;
      $display("FAIL neg_integral got %0d want -5", integ);
    end
  endtask

  task automatic test_en_toggle();
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0),
           6'($urandom), 6'($urandom));
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL en_toggle k=%0d got %h want %h", k, obsv(), expv());
      end
    end
  endtask

  task automatic test_clr_reset();
    for (int k = 0; k < 8; k++) step(1, 0, 6'($urandom), 6'($urandom));
    step(1, 1, 6'b111111, 6'b000000);
    checks++;
    if (obsv() !== '0) begin
      errors++;
      $display("FAIL clr_en got %h want 0", obsv());
    end
    for (int k = 0; k < 5; k++) step(1, 0, 6'($urandom), 6'($urandom));
    #2 init_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obsv() !== '0) begin
      errors++;
      $display("FAIL midreset got %h want 0", obsv());
    end
    #1 init_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 6'($urandom), 6'($urandom));
      checks++;
      if (obsv() !== expv() || wfull !== (k == 16)) begin
        errors++;
        $display("FAIL refill k=%0d got %h want %h", k, obsv(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_pos();
    test_cancel();
    test_saturate();
    test_negative();
    test_en_toggle();
    test_clr_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
